// File: rtl/fetch_mem_arbiter_if.sv
// Fetch/debug/memory bus bundle for fetch_mem_arbiter.
// slave: arbiter side. master: requesters plus memory.
interface fetch_mem_arbiter_if #(
  parameter int AW = 20
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic [15:0]   fetch_data;
  logic          fetch_valid;
  logic          flush;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   dbg_wdata;
  logic          dbg_gnt;
  logic [15:0]   dbg_rdata;
  logic          dbg_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          busy;

  modport slave (
    input  fetch_req, fetch_addr, flush,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_data, fetch_valid,
    output dbg_gnt, dbg_rdata, dbg_valid,
    output mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, flush,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_data, fetch_valid,
    input  dbg_gnt, dbg_rdata, dbg_valid,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Single-port memory arbiter: fetch reads vs debug reads/writes.
// Ports: clock, reset (sync, active-low), bus (fetch_mem_arbiter_if.slave).
// Debug wins; define FETCH_STARVE_GUARD_EN to let fetch in after
// STARVE_LIMIT consecutive debug grants while fetch is waiting.
module fetch_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 20
) (
  input logic                clock,
  input logic                reset,
  fetch_mem_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_chk
    $error("STARVE_LIMIT must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DBG_RD,
    DBG_WR
  } owner_t;

  owner_t        owner_q, owner_d;
  logic          kill_q, kill_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   fdat_q, fdat_d;
  logic [15:0]   ddat_q, ddat_d;

  logic          starve_hit;
  logic          fg, dg;
  logic          fv, dv;
  logic          we;
  logic [AW-1:0] maddr;
  logic [15:0]   wdat, fdat, ddat;

`ifdef FETCH_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  assign starve_hit = bus.fetch_req
                   && (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (!bus.fetch_req || fg)
      starve_d = '0;
    else if (dg && starve_q < LIMIT)
      starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    fg = 1'b0;
    dg = 1'b0;
    priority case (1'b1)
      !reset:        ;
      starve_hit:    fg = 1'b1;
      bus.dbg_req:   dg = 1'b1;
      bus.fetch_req: fg = 1'b1;
      default:       ;
    endcase
  end

  always_comb begin
    owner_d = IDLE;
    kill_d  = 1'b0;
    maddr   = addr_q;
    we      = 1'b0;
    wdat    = '0;
    if (fg) begin
      owner_d = FETCH;
      kill_d  = bus.flush;
      maddr   = bus.fetch_addr;
    end else if (dg) begin
      owner_d = bus.dbg_we ? DBG_WR : DBG_RD;
      maddr   = bus.dbg_addr;
      we      = bus.dbg_we;
      wdat    = bus.dbg_wdata;
    end
    addr_d = maddr;

    // Returns arrive the cycle after the grant;
    // a fetch is dropped if flush hit either cycle.
    fv   = 1'b0;
    dv   = 1'b0;
    fdat = fdat_q;
    ddat = ddat_q;
    if (reset) begin
      unique case (owner_q)
        FETCH: begin
          if (!kill_q && !bus.flush) begin
            fv   = 1'b1;
            fdat = bus.mem_rdata;
          end
        end
        DBG_RD: begin
          dv   = 1'b1;
          ddat = bus.mem_rdata;
        end
        DBG_WR: begin
          dv   = 1'b1;
          ddat = '0;
        end
        default: ;
      endcase
    end
    fdat_d = fdat;
    ddat_d = ddat;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q <= IDLE;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      fdat_q  <= '0;
      ddat_q  <= '0;
    end else begin
      owner_q <= owner_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      fdat_q  <= fdat_d;
      ddat_q  <= ddat_d;
    end
  end

  assign bus.fetch_gnt   = fg;
  assign bus.dbg_gnt     = dg;
  assign bus.mem_addr    = maddr;
  assign bus.mem_we      = we;
  assign bus.mem_wdata   = wdat;
  assign bus.fetch_valid = fv;
  assign bus.fetch_data  = fdat;
  assign bus.dbg_valid   = dv;
  assign bus.dbg_rdata   = ddat;
  assign bus.busy        = (owner_q != IDLE);

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Testbench for fetch_mem_arbiter.
// Vector table plus return scoreboard and corner sequences.
module tb_fetch_mem_arbiter;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fetch_mem_arbiter_if #(.AW(AW)) bus ();

  fetch_mem_arbiter #(
    .STARVE_LIMIT(8),
    .AW(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= 16'hA000 ^ 16'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[9:0]];
  end

  typedef struct {
    logic          fr;
    logic [AW-1:0] fa;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic [15:0]   dd;
    logic          fl;
    logic          efg;
    logic          edg;
  } vec_t;

  typedef struct {
    int          kind;
    logic [15:0] data;
    logic        kill;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic shadow_init();
    for (int i = 0; i < 1024; i++)
      shadow[i] = 16'hA000 ^ 16'(i);
  endtask

  task automatic drive(input vec_t v);
    bus.fetch_req  = v.fr;
    bus.fetch_addr = v.fa;
    bus.dbg_req    = v.dr;
    bus.dbg_we     = v.dw;
    bus.dbg_addr   = v.da;
    bus.dbg_wdata  = v.dd;
    bus.flush      = v.fl;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    exp_t n;
    logic fvx;
    drive(v);
    #4;
    chk("fetch_gnt", bus.fetch_gnt, v.efg);
    chk("dbg_gnt", bus.dbg_gnt, v.edg);
    if (v.efg) begin
      chk("mem_addr_f", bus.mem_addr, v.fa);
      chk("mem_we_f", bus.mem_we, 0);
    end else if (v.edg) begin
      chk("mem_addr_d", bus.mem_addr, v.da);
      chk("mem_we_d", bus.mem_we, v.dw);
      if (v.dw)
        chk("mem_wdata", bus.mem_wdata, v.dd);
    end else begin
      chk("mem_we_idle", bus.mem_we, 0);
    end
    if (sbq.size() > 0) e = sbq.pop_front();
    else e = '{0, 16'h0, 1'b0};
    fvx = (e.kind == 1) && !e.kill && !v.fl;
    chk("fetch_valid", bus.fetch_valid, fvx);
    if (fvx)
      chk("fetch_data", bus.fetch_data, e.data);
    chk("dbg_valid", bus.dbg_valid, e.kind == 2);
    if (e.kind == 2)
      chk("dbg_rdata", bus.dbg_rdata, e.data);
    chk("busy", bus.busy, e.kind != 0);
    n = '{0, 16'h0, 1'b0};
    if (v.efg) begin
      n.kind = 1;
      n.data = shadow[v.fa[9:0]];
      n.kill = v.fl;
    end else if (v.edg) begin
      n.kind = 2;
      n.data = v.dw ? 16'h0 : shadow[v.da[9:0]];
      if (v.dw) shadow[v.da[9:0]] = v.dd;
    end
    sbq.push_back(n);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(int ncyc);
    reset          = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 20'h00055;
    bus.dbg_req    = 1'b1;
    bus.dbg_we     = 1'b1;
    bus.dbg_addr   = 20'h00066;
    bus.dbg_wdata  = 16'h1234;
    bus.flush      = 1'b0;
    #4;
    chk("rst_fetch_gnt", bus.fetch_gnt, 0);
    chk("rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_fvalid_low", bus.fetch_valid, 0);
    chk("rst_dvalid_low", bus.dbg_valid, 0);
    repeat (ncyc) @(posedge clock);
    #1;
    chk("rst_fetch_valid", bus.fetch_valid, 0);
    chk("rst_dbg_valid", bus.dbg_valid, 0);
    chk("rst_fetch_data", bus.fetch_data, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_busy", bus.busy, 0);
    shadow_init();
    sbq.delete();
    bus.fetch_req = 1'b0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    reset         = 1'b1;
  endtask

  vec_t vecs[15];
  vec_t v;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

  initial begin
    //         fr fa       dr dw da       dd        fl fg dg
    vecs[0]  = '{1, 20'h10, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[1]  = '{1, 20'h11, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[2]  = '{1, 20'h12, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[3]  = '{1, 20'h13, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[4]  = '{1, 20'h14, 1, 0, 20'h100, 16'h0,    0, 0, 1};
    vecs[5]  = '{1, 20'h14, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[6]  = '{0, 20'h0,  1, 1, 20'h20,  16'hBEEF, 0, 0, 1};
    vecs[7]  = '{1, 20'h20, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[8]  = '{1, 20'h21, 0, 0, 20'h0,   16'h0,    0, 1, 0};
    vecs[9]  = '{0, 20'h0,  0, 0, 20'h0,   16'h0,    1, 0, 0};
    vecs[10] = '{1, 20'h22, 0, 0, 20'h0,   16'h0,    1, 1, 0};
    vecs[11] = '{0, 20'h0,  0, 0, 20'h0,   16'h0,    0, 0, 0};
    vecs[12] = '{0, 20'h0,  1, 0, 20'h22,  16'h0,    1, 0, 1};
    vecs[13] = '{0, 20'h0,  1, 0, 20'h23,  16'h0,    1, 0, 1};
    vecs[14] = '{0, 20'h0,  0, 0, 20'h0,   16'h0,    0, 0, 0};

    do_reset(3);
    #4;
    @(posedge clock);
    #1;

    for (int i = 0; i < 15; i++)
      step(vecs[i]);

    chk("beef_shadow", shadow[10'h20], 16'hBEEF);

    for (int i = 0; i < 18; i++) begin
      v = '{1, 20'h40, 1, 0, 20'h100, 16'h0, 0, 0, 1};
`ifdef FETCH_STARVE_GUARD_EN
      v.efg = (i % 9 == 8);
      v.edg = !v.efg;
`endif
      step(v);
    end
    step('{1, 20'h41, 0, 0, 20'h0, 16'h0, 0, 1, 0});
    step('{0, 20'h0,  0, 0, 20'h0, 16'h0, 0, 0, 0});

    step('{1, 20'h30, 0, 0, 20'h0, 16'h0, 0, 1, 0});
    do_reset(1);
    step('{0, 20'h0, 0, 0, 20'h0, 16'h0, 0, 0, 0});

    step('{0, 20'h0, 1, 0, 20'h31, 16'h0, 0, 0, 1});
    do_reset(1);
    step('{0, 20'h0, 0, 0, 20'h0, 16'h0, 0, 0, 0});
    step('{1, 20'h32, 0, 0, 20'h0, 16'h0, 0, 1, 0});
    step('{0, 20'h0, 0, 0, 20'h0, 16'h0, 0, 0, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
